// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake, transmitter launch/done and status signals of the arbiter.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic               Arb_en;
  logic [N_REQ-1:0]   Req_valid;
  logic [8*N_REQ-1:0] Req_data;
  logic [N_REQ-1:0]   Req_ready;
  logic               Tx_en;
  logic [7:0]         Tx_data;
  logic               Tx_done;
  logic               Busy;
  logic [2:0]         Grant_id;
  logic               Err_timeout;
  modport master (
    output Arb_en, Req_valid, Req_data, Tx_done,
    input  Req_ready, Tx_en, Tx_data, Busy, Grant_id, Err_timeout
  );
  modport slave (
    input  Arb_en, Req_valid, Req_data, Tx_done,
    output Req_ready, Tx_en, Tx_data, Busy, Grant_id, Err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter among N_REQ producers,
// with an inter-byte gap and a watchdog on the transmitter's done pulse.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             Clk,
  input  logic             Rst,
  uart_tx_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;
  state_t      state, state_d;
  logic [2:0]  rr_ptr, win;
  logic [3:0]  idx;
  logic [7:0]  vld;
  logic [63:0] dat;
  logic [15:0] wd_cnt;
  logic [7:0]  gap_cnt;
  logic        hit, grant, expire;
  assign vld = 8'(bus.Req_valid);
  assign dat = 64'(bus.Req_data);
  // Scan downwards so the last hit, i.e. the closest index at or after rr_ptr, wins.
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + 4'(k);
      idx = idx >= 4'(N_REQ) ? idx - 4'(N_REQ) : idx;
      if (vld[idx[2:0]]) begin
        win = idx[2:0];
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      state_d = grant ? WAIT_DONE : IDLE;
      WAIT_DONE: state_d = (bus.Tx_done || expire) ? GAP : WAIT_DONE;
      GAP:       state_d = gap_cnt == 8'(GAP_CYCLES - 1) ? IDLE : GAP;
      default:   state_d = IDLE;
    endcase
  end
  // A done pulse in the final watchdog cycle wins, so expiry requires done low.
  always_comb begin
    grant    = state == IDLE && bus.Arb_en && hit;
    expire   = state == WAIT_DONE && !bus.Tx_done && wd_cnt == 16'(TIMEOUT_CYCLES - 1);
    bus.Busy = state != IDLE;
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rr_ptr          <= '0;
      wd_cnt          <= '0;
      gap_cnt         <= '0;
      bus.Req_ready   <= '0;
      bus.Tx_en       <= 1'b0;
      bus.Tx_data     <= 8'h00;
      bus.Grant_id    <= '0;
      bus.Err_timeout <= 1'b0;
    end else begin
      wd_cnt          <= state == WAIT_DONE && state_d == WAIT_DONE ? wd_cnt + 16'd1 : '0;
      gap_cnt         <= state == GAP && state_d == GAP ? gap_cnt + 8'd1 : '0;
      bus.Req_ready   <= grant ? N_REQ'(8'd1 << win) : '0;
      bus.Tx_en       <= grant;
      bus.Err_timeout <= expire;
      if (grant) begin
        rr_ptr       <= win == 3'(N_REQ - 1) ? '0 : win + 3'd1;
        bus.Tx_data  <= dat[{win, 3'b000} +: 8];
        bus.Grant_id <= win;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized grant rounds against a transaction-level
// round-robin model; the bench also plays the transmitter.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int GAP = 2;
  localparam int TO  = 100;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rr = 0;
  uart_tx_arbiter_if #(.N_REQ(N)) bus ();
  uart_tx_arbiter #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .Clk(clk),
    .Rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [N-1:0] mask, input int ptr);
    for (int k = 0; k < N; k++)
      if (mask[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction
  task automatic churn();
    bus.Req_valid = N'($urandom);
    bus.Req_data  = $urandom;
    bus.Arb_en    = 1'($urandom);
  endtask
  // Entered and left at the falling edge of an IDLE cycle.
  task automatic grant_round(input logic [N-1:0] mask, input logic [8*N-1:0] data,
                             input bit en, input int len, input bit done);
    int w;
    logic [7:0] b;
    bus.Req_valid = mask;
    bus.Req_data  = data;
    bus.Arb_en    = en;
    bus.Tx_done   = 1'b0;
    check("idle_busy", bus.Busy, 0);
    w = en ? pick(mask, rr) : -1;
    @(negedge clk);
    if (w < 0) begin
      check("no_grant", {bus.Req_ready, bus.Tx_en, bus.Busy}, 0);
      return;
    end
    b  = data[8*w +: 8];
    rr = (w + 1) % N;
    check("ready", bus.Req_ready, 32'(1) << w);
    check("tx_en", bus.Tx_en, 1);
    check("tx_data", bus.Tx_data, b);
    check("grant_id", bus.Grant_id, w);
    check("busy_grant", bus.Busy, 1);
    for (int j = 1; j <= len; j++) begin
      churn();
      @(negedge clk);
      check("wait_quiet", {bus.Tx_en, bus.Req_ready, bus.Err_timeout}, 0);
      check("wait_hold", {bus.Busy, bus.Tx_data}, {1'b1, b});
      bus.Tx_done = done && j == len;
    end
    @(negedge clk);
    check("err_timeout", bus.Err_timeout, !done);
    check("gap_busy", {bus.Busy, bus.Tx_en}, 2'b10);
    for (int g = 1; g < GAP; g++) begin
      bus.Tx_done = 1'($urandom);
      churn();
      @(negedge clk);
      check("gap_quiet", {bus.Busy, bus.Tx_en, bus.Err_timeout, bus.Tx_data}, {3'b100, b});
    end
    bus.Tx_done = 1'($urandom);
    churn();
    @(negedge clk);
    bus.Tx_done = 1'b0;
    check("idle_hold", bus.Tx_data, b);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
  initial begin
    int act;
    bit d;
    int len;
    bus.Arb_en    = 1'b0;
    bus.Req_valid = '0;
    bus.Req_data  = '0;
    bus.Tx_done   = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_vals", {bus.Busy, bus.Tx_en, bus.Req_ready, bus.Tx_data, bus.Grant_id, bus.Err_timeout}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.Arb_en    = 1'b0;
    bus.Req_valid = '1;
    act = 0;
    repeat (1000) begin
      @(negedge clk);
      act += int'(bus.Req_ready != 0 || bus.Tx_en || bus.Busy);
    end
    check("gated_activity", act, 0);
    for (int r = 0; r < 5; r++) grant_round(4'hf, 32'h13121110, 1'b1, 3 + r, 1'b1);
    grant_round(4'b0100, 32'h00A50000, 1'b1, 7, 1'b1);
    grant_round(4'b0010, $urandom, 1'b1, 2, 1'b1);
    grant_round(4'b1001, $urandom, 1'b1, 2, 1'b1);
    grant_round(4'b1001, $urandom, 1'b1, 2, 1'b1);
    grant_round(4'b0001, $urandom, 1'b1, TO - 1, 1'b0);
    grant_round(4'b0001, $urandom, 1'b1, TO - 1, 1'b1);
    grant_round(4'b0001, $urandom, 1'b1, TO - 2, 1'b1);
    grant_round(4'b1111, $urandom, 1'b0, 1, 1'b1);
    bus.Arb_en    = 1'b1;
    bus.Req_valid = 4'b0110;
    bus.Req_data  = $urandom;
    @(negedge clk);
    check("rst_pre_busy", bus.Busy, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", {bus.Busy, bus.Tx_en, bus.Req_ready, bus.Tx_data, bus.Grant_id, bus.Err_timeout}, 0);
    @(negedge clk);
    rst = 1'b0;
    rr = 0;
    bus.Req_valid = '0;
    bus.Tx_done   = 1'b1;
    @(negedge clk);
    check("spurious_done", {bus.Busy, bus.Tx_en, bus.Err_timeout}, 0);
    bus.Tx_done = 1'b0;
    grant_round(4'b1010, $urandom, 1'b1, 3, 1'b1);
    for (int r = 0; r < 40; r++) begin
      d   = ($urandom % 4) != 0;
      len = (!d || $urandom % 6 == 0) ? TO - 1 : int'($urandom_range(12, 1));
      grant_round(N'($urandom), $urandom, ($urandom % 5) != 0, len, d);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
